mu0_seq_alu: RTL and testbench
==============================

MU0_SEQ_ALU -- requirements
Module: mu0_seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, datapath width in bits (WIDTH >= 4).
REQ-002 SHALL provide port Clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port Start  input  1  request; operands and mode sampled when Start=1 in IDLE.
REQ-005 SHALL provide port M  input  3  operation select.
REQ-006 SHALL provide port X  input  WIDTH  operand A.
REQ-007 SHALL provide port Y  input  WIDTH  operand B.
REQ-008 SHALL provide port Q  output  WIDTH  registered result.
REQ-009 SHALL provide port Busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 SHALL provide port Done  output  1  one-cycle pulse: Q and flags newly valid.
REQ-011 SHALL provide ports N, Z, C  output  1 each  registered negative, zero and carry flags.

Function
REQ-012 SHALL implement ops: 000 Q=Y; 001 X+Y; 010 X+1; 011 X-Y; 100 X&Y; 101 X|Y; 110 arithmetic shift right of X by 1; 111 unsigned X*Y, low WIDTH bits.
REQ-013 SHALL compute all arithmetic modulo 2^WIDTH, with wrap-around and no saturation.
REQ-014 SHALL set C to: carry-out for 001/010; 1 when X>=Y unsigned (no borrow) for 011; bit 0 of X for 110; 1 when the high WIDTH product bits are nonzero for 111; 0 otherwise.
REQ-015 SHALL set N=Q[WIDTH-1] and Z=(Q==0), updated only together with Q.
REQ-016 SHALL use FSM states IDLE and MUL: IDLE->MUL on Start=1 with M=111; MUL->IDLE after WIDTH iterations; all other Start requests remain in IDLE.
REQ-017 SHALL, for ops 000-110 sampled at edge n, load Q/N/Z/C at edge n and drive Done=1 for exactly the following cycle (latency 1).
REQ-018 SHALL, for op 111 sampled at edge n, hold Busy=1 from edge n to edge n+WIDTH, process one multiplier bit per cycle (shift-add), and load Q/flags with Done=1 and Busy=0 at edge n+WIDTH.
REQ-019 SHALL capture X, Y and M at acceptance; operand changes while Busy=1 SHALL NOT affect the result.
REQ-020 SHALL ignore Start while Busy=1; no queuing, and Q/flags are unchanged by the ignored request.
REQ-021 SHALL accept Start in the cycle Done=1, when in IDLE, giving back-to-back operation with no bubble.
REQ-022 SHALL hold Q and flags stable between Done pulses; Done SHALL never stay high for two consecutive cycles unless two single-cycle ops are accepted back-to-back.
REQ-023 SHALL keep Q and flags unchanged during MUL, with no partial products visible on Q.

Reset
REQ-024 SHALL, on Reset=1 at any time, immediately force IDLE, Q=0, N=0, Z=0, C=0, Busy=0, Done=0, independent of Clk.
REQ-025 SHALL, on Reset asserted mid-multiply, abort the operation; no Done is produced for it.
REQ-026 SHALL ignore Start for the whole time Reset=1; the first acceptable edge follows Reset deassertion.

Verification
REQ-027 SHALL verify reset: assert Reset with no clock -> Q=0000, N=Z=C=0, Busy=0, Done=0.
REQ-028 SHALL verify ADD (WIDTH=16): M=001, X=FFFF, Y=0001, Start -> next cycle Q=0000, Z=1, C=1, N=0, Done high for one cycle.
REQ-029 SHALL verify SUB: M=011, X=0003, Y=0005 -> Q=FFFE, N=1, Z=0, C=0; then X=0005, Y=0003 back-to-back -> Q=0002, C=1.
REQ-030 SHALL verify MUL: M=111, X=0012, Y=0034 -> Busy high 16 cycles, then Q=03A8, C=0, Done pulse; an ADD Start issued during Busy is ignored and X/Y are changed mid-op without effect.
REQ-031 SHALL verify MUL overflow: X=0100, Y=0100 -> Q=0000, Z=1, C=1 after 16 cycles.
REQ-032 SHALL verify mid-operation reset: Reset pulsed 5 cycles into a MUL -> all outputs 0 immediately, no Done; the next ADD X=0001, Y=0001 -> Q=0002.

Source files
------------

// File: rtl/mu0_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mu0_seq_alu
//  Purpose  : MU0-style ALU. Ops 000-110 finish in one cycle. Op 111 is an
//             unsigned shift-add multiply that processes one multiplier bit
//             per cycle over WIDTH cycles. Q and the N/Z/C flags are
//             registered and change only when Done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module mu0_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             N,
  output logic             Z,
  output logic             C
);

  localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [2:0]         c_OP_MUL = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_start_single;
  logic                 w_start_mul;
  logic                 w_mul_last;

  logic [WIDTH-1:0]     r_q;
  logic                 r_n;
  logic                 r_z;
  logic                 r_c;
  logic                 r_done;

  // Multiply working registers: accumulator, shifted multiplicand, multiplier
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   w_acc_next;

  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_inc;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cy;

  // Extra top bit holds carry-out (add/inc) or borrow (sub)
  assign w_add = {1'b0, X} + {1'b0, Y};
  assign w_inc = {1'b0, X} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sub = {1'b0, X} - {1'b0, Y};

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

  // Single-cycle result and carry selection for ops 000-110
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (M)
      3'b000: w_res = Y;
      3'b001: begin w_res = w_add[WIDTH-1:0]; w_cy = w_add[WIDTH]; end
      3'b010: begin w_res = w_inc[WIDTH-1:0]; w_cy = w_inc[WIDTH]; end
      3'b011: begin w_res = w_sub[WIDTH-1:0]; w_cy = ~w_sub[WIDTH]; end
      3'b100: w_res = X & Y;
      3'b101: w_res = X | Y;
      3'b110: begin w_res = {X[WIDTH-1], X[WIDTH-1:1]}; w_cy = X[0]; end
      default: begin w_res = '0; w_cy = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic and operation-acceptance strobes
  always_comb begin
    w_state_next   = r_state;
    w_start_single = 1'b0;
    w_start_mul    = 1'b0;
    w_mul_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (M == c_OP_MUL) begin
            w_start_mul  = 1'b1;
            w_state_next = S_MUL;
          end else begin
            w_start_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == c_LAST) begin
          w_mul_last   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: result/flag registers, Done pulse and shift-add iteration
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q      <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_single) begin
        r_q    <= w_res;
        r_n    <= w_res[WIDTH-1];
        r_z    <= (w_res == '0);
        r_c    <= w_cy;
        r_done <= 1'b1;
      end
      if (w_start_mul) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, X};
        r_mplier <= Y;
        r_cnt    <= '0;
      end
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + c_CNT_W'(1);
        // Q is only touched once the final partial sum is formed
        if (w_mul_last) begin
          r_q    <= w_acc_next[WIDTH-1:0];
          r_n    <= w_acc_next[WIDTH-1];
          r_z    <= (w_acc_next[WIDTH-1:0] == '0);
          r_c    <= |w_acc_next[2*WIDTH-1:WIDTH];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign Q    = r_q;
  assign N    = r_n;
  assign Z    = r_z;
  assign C    = r_c;
  assign Done = r_done;
  assign Busy = (r_state == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_mu0_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mu0_seq_alu
//  Purpose  : Scoreboard bench for mu0_seq_alu with directed and random ops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mu0_seq_alu;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   M = 3'b000;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic [W-1:0] Q;
  logic         Busy, Done, N, Z, C;
  bit           clk_en = 1'b0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         n;
    logic         z;
    logic         c;
  } res_t;

  res_t sb[$];
  res_t last_res = '0;
  res_t hold_res = '0;
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt;

  mu0_seq_alu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .M(M), .X(X), .Y(Y),
    .Q(Q), .Busy(Busy), .Done(Done), .N(N), .Z(Z), .C(C)
  );

  always #5 if (clk_en) Clk = ~Clk;

  // Reference model straight from the operation table
  function automatic res_t model(int m, int unsigned x, int unsigned y);
    res_t r;
    longint unsigned full;
    r = '0;
    full = 0;
    case (m)
      0: full = y;
      1: begin full = longint'(x) + y; r.c = (full >= 65536); end
      2: begin full = longint'(x) + 1; r.c = (full >= 65536); end
      3: begin full = (longint'(x) + 65536 - y) % 65536; r.c = (x >= y); end
      4: full = x & y;
      5: full = x | y;
      6: begin full = (x >> 1) | (x & 32'h8000); r.c = x[0]; end
      default: begin full = longint'(x) * longint'(y); r.c = (full >= 65536); end
    endcase
    r.q = full[W-1:0];
    r.n = (r.q >= 16'h8000);
    r.z = (r.q == 0);
    return r;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse consumes one scoreboard entry
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", Done, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("q", Q, mon_e.q);
        chk("n", N, mon_e.n);
        chk("z", Z, mon_e.z);
        chk("c", C, mon_e.c);
      end
    end
  end

  task automatic issue(int m, int unsigned x, int unsigned y, bit push);
    @(negedge Clk);
    Start = 1'b1;
    M = m[2:0];
    X = x[W-1:0];
    Y = y[W-1:0];
    if (push) begin
      hold_res = last_res;
      last_res = model(m, x, y);
      sb.push_back(last_res);
    end
  endtask

  task automatic idle();
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Runs the busy phase of a multiply, poking a Start and operand changes
  task automatic wait_mul(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      cnt++;
      chk("q_hold", Q, hold_res.q);
      if (i == 0) begin
        Start = 1'b1; M = 3'b001; X = W'($urandom); Y = W'($urandom);
      end else if (i == 1) begin
        Start = 1'b0;
      end else if (i == 4) begin
        X = W'($urandom); Y = W'($urandom);
      end
    end
  endtask

  task automatic run_op(int m, int unsigned x, int unsigned y);
    issue(m, x, y, 1'b1);
    if (m == 7) begin
      wait_mul(busy_cnt);
      chk("busy_cycles", busy_cnt, W);
    end
  endtask

  initial begin
    // Asynchronous reset with no clock running
    #2 Reset = 1'b1;
    #1;
    chk("rst_q", Q, 0);
    chk("rst_n", N, 0);
    chk("rst_z", Z, 0);
    chk("rst_c", C, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Start = 1'b1; M = 3'b001; X = 16'h0001; Y = 16'h0001;
    #2 clk_en = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    chk("q_after_rst_start", Q, 0);

    // ADD wrap with carry, Done must last one cycle
    run_op(1, 32'hFFFF, 32'h0001);
    idle();
    @(negedge Clk);
    chk("done_pulse", Done, 0);

    // SUB negative then back-to-back SUB positive
    run_op(3, 32'h0003, 32'h0005);
    run_op(3, 32'h0005, 32'h0003);
    idle();

    // MUL with ignored Start and operand changes, then overflow MUL
    run_op(7, 32'h0012, 32'h0034);
    run_op(7, 32'h0100, 32'h0100);

    // Reset five cycles into a multiply
    issue(7, 32'h0033, 32'h0077, 1'b0);
    idle();
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("mrst_q", Q, 0);
    chk("mrst_n", N, 0);
    chk("mrst_z", Z, 0);
    chk("mrst_c", C, 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_done", Done, 0);
    last_res = '0;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("mrst_no_done", Done, 0);
      chk("mrst_idle", Busy, 0);
    end
    run_op(1, 32'h0001, 32'h0001);
    idle();

    // Random ops, frequently back-to-back
    for (int k = 0; k < 40; k++) begin
      int m;
      m = $urandom_range(0, 7);
      run_op(m, $urandom_range(0, 65535), $urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) idle();
    end
    // Boundary operands
    run_op(6, 32'h8001, 32'h0000);
    run_op(2, 32'hFFFF, 32'h0000);
    run_op(3, 32'h1234, 32'h1234);
    run_op(7, 32'hFFFF, 32'hFFFF);
    idle();

    repeat (4) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
